// File: rtl/input_debounce.sv
// Per-channel input conditioner: 2-flop synchroniser, stability-counter debounce,
// registered rise/fall pulses and a toggle bit that flips on each rising edge.
module input_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             gclk10,
  input  logic             btn_center,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] toggle
);

  localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [WIDTH-1:0]           s1_q, s2_q;
  logic [WIDTH-1:0]           level_q, level_d;
  logic [WIDTH-1:0]           rise_q, rise_d;
  logic [WIDTH-1:0]           fall_q, fall_d;
  logic [WIDTH-1:0]           toggle_q, toggle_d;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the accepted
  // level; any agreement clears it, so stability always restarts from zero.
  always_comb begin
    level_d  = level_q;
    toggle_d = toggle_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
          if (s2_q[i]) begin
            toggle_d[i] = ~toggle_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  always_ff @(posedge gclk10 or posedge btn_center) begin
    if (btn_center) begin
      s1_q     <= {WIDTH{RESET_LEVEL}};
      s2_q     <= {WIDTH{RESET_LEVEL}};
      level_q  <= {WIDTH{RESET_LEVEL}};
      toggle_q <= {WIDTH{RESET_LEVEL}};
      rise_q   <= '0;
      fall_q   <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_in;
      s2_q     <= s1_q;
      level_q  <= level_d;
      toggle_q <= toggle_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule
